// File: rtl/agri_periph_pkg.sv
// Shared definitions for the agricultural sensor peripherals: AHB-Lite
// encodings, register offsets, register bit positions and FSM state encoding.
package agri_periph_pkg;

    // AHB-Lite transfer encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Register word index (HADDR[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    // CTRL bits
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    // STATUS bits
    localparam int STATUS_EMPTY   = 0;
    localparam int STATUS_FULL    = 1;
    localparam int STATUS_OVERRUN = 2;
    localparam int STATUS_CNT_LSB = 8;

    // Bus-side FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Assemble the STATUS word from its fields
    function automatic logic [31:0] status_word(input logic empty, input logic full,
                                                input logic overrun, input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STATUS_EMPTY]   = empty;
        w[STATUS_FULL]    = full;
        w[STATUS_OVERRUN] = overrun;
        w[STATUS_CNT_LSB +: 8] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/agri_sync_fifo.sv
// Single-clock FIFO with flush. Head word is presented combinationally on
// rdata_o; pointers wrap naturally modulo the power-of-two depth.
module agri_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flush overrides both push and pop in the same cycle
    assign do_push = push_i & ~full_o  & ~flush_i;
    assign do_pop  = pop_i  & ~empty_o & ~flush_i;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ahb_sensor_fifo_slave.sv
// AHB-Lite responder buffering sensor samples in a FIFO behind a four-register
// map (CTRL, STATUS, DATA, THRESH). A DATA read on an empty FIFO stalls the bus
// until a sample arrives or the wait budget expires, then answers ERROR.
module ahb_sensor_fifo_slave
    import agri_periph_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int SAMPLE_W   = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    input  logic                HWRITE,
    input  logic [31:0]         HADDR,
    input  logic [31:0]         HWDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    input  logic                SAMPLE_VALID,
    input  logic [SAMPLE_W-1:0] SAMPLE_DATA,
    output logic                SAMPLE_READY,
    output logic                IRQ
);

    localparam int         CNT_W   = DEPTH_LOG2 + 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // FSM and data-phase registers
    state_e      state_q, state_d;
    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic [1:0]  dp_reg_q, dp_reg_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    // Register bank
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;

    // FIFO interface
    logic                push, pop, flush;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [7:0]          count8;

    logic acc, legal, empty_next;
    logic dp_done, wr_fire, rd_fire;
    logic unused_bits;

    assign unused_bits = ^{HTRANS[0], HADDR[31:12], HWDATA[31:8]};

    assign acc    = HSEL & HREADY & HTRANS[1];
    assign count8 = 8'(fifo_count);

    // Legality of the address phase currently on the bus; the slot decodes 4 KB
    always_comb begin
        legal = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00) && (HADDR[11:4] == 8'h00)
                && !(HWRITE && ((HADDR[3:2] == REG_STATUS) || (HADDR[3:2] == REG_DATA)));
    end

    // A registered legal transfer completes in the first IDLE cycle of its data phase
    assign dp_done = (state_q == ST_IDLE) & dp_valid_q;
    assign wr_fire = dp_done & dp_write_q;
    assign rd_fire = dp_done & ~dp_write_q;

    assign SAMPLE_READY = en_q & ~fifo_full;
    assign push  = SAMPLE_VALID & SAMPLE_READY;
    assign pop   = rd_fire & (dp_reg_q == REG_DATA);
    assign flush = wr_fire & (dp_reg_q == REG_CTRL) & HWDATA[CTRL_FLUSH];

    // FIFO occupancy as the next data phase will see it, so a DATA read
    // accepted while the previous DATA read drains the last entry still waits
    always_comb begin
        empty_next = flush
                   | ((fifo_count == '0) & ~push)
                   | ((fifo_count == CNT_W'(1)) & pop & ~push);
    end

    agri_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (SAMPLE_W)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (SAMPLE_DATA),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bus FSM next-state, data-phase capture and response outputs
    always_comb begin
        state_d    = state_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_reg_d   = dp_reg_q;
        wait_cnt_d = '0;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                HRESP      = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                dp_valid_d = 1'b0;
                state_d    = ST_IDLE;
                if (acc) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else begin
                        dp_valid_d = 1'b1;
                        dp_write_d = HWRITE;
                        dp_reg_d   = HADDR[3:2];
                        if (!HWRITE && (HADDR[3:2] == REG_DATA) && empty_next)
                            state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (push) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d    = ST_ERR1;
                    dp_valid_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data mux, driven only while a read completes
    always_comb begin
        HRDATA = '0;
        if (rd_fire) begin
            unique case (dp_reg_q)
                REG_CTRL:   HRDATA = {29'd0, 1'b0, irq_en_q, en_q};
                REG_STATUS: HRDATA = status_word(fifo_empty, fifo_full, overrun_q, count8);
                REG_DATA:   HRDATA = 32'(fifo_rdata);
                default:    HRDATA = {24'd0, thresh_q};
            endcase
        end
    end

    // Register bank, overrun flag and interrupt next-state
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr_fire && (dp_reg_q == REG_CTRL)) begin
            en_d     = HWDATA[CTRL_EN];
            irq_en_d = HWDATA[CTRL_IRQ_EN];
        end
        if (wr_fire && (dp_reg_q == REG_THRESH)) begin
            thresh_d = HWDATA[7:0];
        end
        overrun_d = (SAMPLE_VALID & en_q & fifo_full)
                  | (overrun_q & ~(rd_fire & (dp_reg_q == REG_STATUS)));
        irq_d = irq_en_q & (((thresh_q != 8'd0) & (count8 >= thresh_q)) | overrun_q);
    end

    assign IRQ = irq_q;

    // State registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_reg_q   <= '0;
            wait_cnt_q <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= '0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_reg_q   <= dp_reg_d;
            wait_cnt_q <= wait_cnt_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_ahb_sensor_fifo_slave.sv
// Directed bench for ahb_sensor_fifo_slave: register access, FIFO data path,
// empty-FIFO wait states, wait timeout, ERROR responses, overrun and IRQ.
module tb_ahb_sensor_fifo_slave;

    localparam int DEPTH_LOG2 = 4;
    localparam int SAMPLE_W   = 16;
    localparam int TIMEOUT    = 255;

    localparam logic [31:0] A_CTRL   = 32'h0000_0000;
    localparam logic [31:0] A_STATUS = 32'h0000_0004;
    localparam logic [31:0] A_DATA   = 32'h0000_0008;
    localparam logic [31:0] A_THRESH = 32'h0000_000C;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic                HSEL;
    logic                HREADY;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic                HWRITE;
    logic [31:0]         HADDR;
    logic [31:0]         HWDATA;
    logic                HREADYOUT;
    logic                HRESP;
    logic [31:0]         HRDATA;
    logic                SAMPLE_VALID;
    logic [SAMPLE_W-1:0] SAMPLE_DATA;
    logic                SAMPLE_READY;
    logic                IRQ;

    int n_checks = 0;
    int n_errors = 0;

    // Single-slave bus: the HREADY mux output is this slave's HREADYOUT
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_sensor_fifo_slave #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .SAMPLE_W   (SAMPLE_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSEL         (HSEL),
        .HREADY       (HREADY),
        .HTRANS       (HTRANS),
        .HSIZE        (HSIZE),
        .HWRITE       (HWRITE),
        .HADDR        (HADDR),
        .HWDATA       (HWDATA),
        .HREADYOUT    (HREADYOUT),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_DATA  (SAMPLE_DATA),
        .SAMPLE_READY (SAMPLE_READY),
        .IRQ          (IRQ)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One AHB transfer; starts and ends one time unit after a rising edge
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic resp, output int lo, output int lo_err);
        logic done;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = wdata;
        lo = 0; lo_err = 0; done = 1'b0; rdata = '0; resp = 1'b0;
        for (int g = 0; g < 1000 && !done; g++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                rdata = HRDATA; resp = HRESP; done = 1'b1;
            end else begin
                lo++;
                if (HRESP) lo_err++;
            end
            @(posedge HCLK); #1;
        end
        if (!done) check_eq("xfer_done", {31'd0, done}, 32'd1);
    endtask

    task automatic reg_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic rs; int lo, le;
        ahb_xfer(1'b1, addr, 3'b010, data, rd, rs, lo, le);
        check_eq({tag, "_okay0ws"}, {lo[15:0], 15'd0, rs}, 32'd0);
    endtask

    task automatic reg_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic rs; int lo, le;
        ahb_xfer(1'b0, addr, 3'b010, 32'd0, rd, rs, lo, le);
        check_eq({tag, "_okay0ws"}, {lo[15:0], 15'd0, rs}, 32'd0);
        check_eq(tag, rd, exp);
    endtask

    // Expect the two-cycle ERROR: one low cycle with HRESP=1, then HRESP=1 ready
    task automatic err_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] rd; logic rs; int lo, le;
        ahb_xfer(wr, addr, size, wdata, rd, rs, lo, le);
        check_eq(tag, {8'd0, lo[7:0], le[7:0], 7'd0, rs}, 32'h0001_0101);
    endtask

    task automatic push_sample(input logic [SAMPLE_W-1:0] d);
        SAMPLE_VALID = 1'b1; SAMPLE_DATA = d;
        @(posedge HCLK); #1;
        SAMPLE_VALID = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rs;
        int          lo, le;

        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; SAMPLE_VALID = 1'b0; SAMPLE_DATA = '0;
        repeat (3) @(posedge HCLK);
        #1;

        // Reset state
        @(negedge HCLK);
        check_eq("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check_eq("rst_hresp", {31'd0, HRESP}, 32'd0);
        check_eq("rst_hrdata", HRDATA, 32'd0);
        check_eq("rst_irq", {31'd0, IRQ}, 32'd0);
        check_eq("rst_sready", {31'd0, SAMPLE_READY}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        reg_read("rst_status", A_STATUS, 32'h0000_0001);
        reg_read("rst_ctrl", A_CTRL, 32'd0);
        reg_read("rst_thresh", A_THRESH, 32'd0);

        // 1: basic push/pop ordering
        reg_write("t1_ctrl_wr", A_CTRL, 32'h1);
        push_sample(16'h0011);
        push_sample(16'h0022);
        push_sample(16'h0033);
        reg_read("t1_status3", A_STATUS, 32'h0000_0300);
        reg_read("t1_data0", A_DATA, 32'h0000_0011);
        reg_read("t1_data1", A_DATA, 32'h0000_0022);
        reg_read("t1_data2", A_DATA, 32'h0000_0033);
        reg_read("t1_status", A_STATUS, 32'h0000_0001);

        // 2: empty-FIFO read, sample valid in the 6th wait cycle
        fork
            ahb_xfer(1'b0, A_DATA, 3'b010, 32'd0, rd, rs, lo, le);
            begin
                repeat (6) @(posedge HCLK);
                #1;
                SAMPLE_VALID = 1'b1; SAMPLE_DATA = 16'hBEEF;
                @(posedge HCLK); #1;
                SAMPLE_VALID = 1'b0;
            end
        join
        check_eq("t2_wait_cycles", 32'(lo), 32'd6);
        check_eq("t2_rdata", rd, 32'h0000_BEEF);
        check_eq("t2_resp", {31'd0, rs}, 32'd0);
        reg_read("t2_status", A_STATUS, 32'h0000_0001);

        // 3: empty-FIFO read that times out
        ahb_xfer(1'b0, A_DATA, 3'b010, 32'd0, rd, rs, lo, le);
        check_eq("t3_low_cycles", 32'(lo), 32'(TIMEOUT + 1));
        check_eq("t3_err1_cycles", 32'(le), 32'd1);
        check_eq("t3_err2_resp", {31'd0, rs}, 32'd1);
        reg_read("t3_status", A_STATUS, 32'h0000_0001);

        // 4: illegal accesses, no side effects
        err_xfer("t4_byte_ctrl", 1'b1, A_CTRL, 3'b000, 32'h0);
        reg_read("t4_ctrl_kept", A_CTRL, 32'h0000_0001);
        err_xfer("t4_wr_status", 1'b1, A_STATUS, 3'b010, 32'hFFFF_FFFF);
        reg_read("t4_status_kept", A_STATUS, 32'h0000_0001);
        err_xfer("t4_off_0x10", 1'b0, 32'h0000_0010, 3'b010, 32'h0);
        err_xfer("t4_misalign", 1'b0, 32'h0000_0002, 3'b010, 32'h0);
        reg_read("t4_ctrl_kept2", A_CTRL, 32'h0000_0001);

        // 5: fill to full with SAMPLE_VALID held for 17 cycles
        SAMPLE_VALID = 1'b1;
        for (int i = 0; i < 17; i++) begin
            SAMPLE_DATA = 16'h0100 + 16'(i);
            @(negedge HCLK);
            if (i == 15) check_eq("t5_ready_last_slot", {31'd0, SAMPLE_READY}, 32'd1);
            if (i == 16) check_eq("t5_ready_full", {31'd0, SAMPLE_READY}, 32'd0);
            @(posedge HCLK); #1;
        end
        SAMPLE_VALID = 1'b0;
        reg_read("t5_status_ovr", A_STATUS, 32'h0000_1006);
        reg_read("t5_status_clr", A_STATUS, 32'h0000_1002);
        reg_read("t5_head", A_DATA, 32'h0000_0100);
        reg_read("t5_status15", A_STATUS, 32'h0000_0F00);
        reg_write("t5_flush", A_CTRL, 32'h5);
        reg_read("t5_ctrl_flush0", A_CTRL, 32'h0000_0001);
        reg_read("t5_status_flushed", A_STATUS, 32'h0000_0001);

        // 6: threshold interrupt
        reg_write("t6_thresh_wr", A_THRESH, 32'h4);
        reg_read("t6_thresh", A_THRESH, 32'h0000_0004);
        reg_write("t6_ctrl_wr", A_CTRL, 32'h3);
        push_sample(16'h0001);
        push_sample(16'h0002);
        push_sample(16'h0003);
        push_sample(16'h0004);
        check_eq("t6_irq_same_cycle", {31'd0, IRQ}, 32'd0);
        @(posedge HCLK); #1;
        check_eq("t6_irq_rise", {31'd0, IRQ}, 32'd1);
        reg_read("t6_pop", A_DATA, 32'h0000_0001);
        check_eq("t6_irq_hold", {31'd0, IRQ}, 32'd1);
        @(posedge HCLK); #1;
        check_eq("t6_irq_fall", {31'd0, IRQ}, 32'd0);

        // 6: reset asserted while waiting on an empty FIFO
        reg_write("t6_flush", A_CTRL, 32'h5);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = A_DATA; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        repeat (3) @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check_eq("t6_waiting", {31'd0, HREADYOUT}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        check_eq("t6_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check_eq("t6_rst_hresp", {31'd0, HRESP}, 32'd0);
        check_eq("t6_rst_hrdata", HRDATA, 32'd0);
        check_eq("t6_rst_irq", {31'd0, IRQ}, 32'd0);
        HRESETn = 1'b1;
        reg_read("t6_rst_status", A_STATUS, 32'h0000_0001);
        reg_read("t6_rst_ctrl", A_CTRL, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
